// File: rtl/led_sched_pkg.sv
// led_sched_pkg
//   Shared types and widths for the LED scheduler.
//   state_e : scheduler FSM states
//   PAT_W   : blink pattern width (played MSB first)
//   REP_W   : extra-repetition counter width
//   STEP_W  : pattern step index width (wraps naturally at PAT_W steps)
package led_sched_pkg;

    localparam int PAT_W  = 16;
    localparam int REP_W  = 4;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Free-running prescaler that divides clk down to one step tick.
//   The count runs 0..STEP_CYCLES-1 and wraps; tick is high for the
//   single cycle in which the count sits at STEP_CYCLES-1.
//   Ports:
//     clk    : system clock
//     in_rst : asynchronous active-low reset
//     clr    : synchronous clear of the count (takes priority over wrap)
//     tick   : one-cycle step strobe
module tick_gen #(
    parameter int STEP_CYCLES = 1600000
) (
    input  logic clk,
    input  logic in_rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scheduler.sv
// led_scheduler
//   Shares one board LED between N_REQ requesters. Each requester asks to
//   play a 16-bit blink pattern (MSB first), repeated reps+1 times. A
//   fixed-priority arbiter (index 0 highest) grants only from S_IDLE, so a
//   playing pattern is never preempted. With no grant active the LED shows
//   a heartbeat that toggles every HB_STEPS step ticks.
//
//   Handshake: req[i] is a level held by requester i until it sees
//   ack[i]. ack is a one-cycle one-hot pulse issued on the edge where the
//   winner's pattern/reps are latched; a req dropped before ack is simply
//   never granted. done pulses for one cycle when the granted pattern ends.
//
//   Ports:
//     clk         : system clock (16 MHz)
//     in_rst      : asynchronous active-low reset
//     req         : per-requester request level
//     pattern     : flattened patterns, slice i = [16*i+15:16*i]
//     reps        : flattened extra repetitions, slice i = [4*i+3:4*i]
//     ack         : one-cycle one-hot grant pulse
//     busy        : high while a pattern is playing
//     gnt_id      : index of the active grantee, 0 when idle
//     done        : one-cycle pulse at the end of a granted pattern
//     LED         : LED drive
//     dbg_state_o : current FSM state
module led_scheduler
    import led_sched_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int STEP_CYCLES = 1600000,
    parameter int HB_STEPS    = 5,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   in_rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PAT_W-1:0] pattern,
    input  logic [N_REQ*REP_W-1:0] reps,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   done,
    output logic                   LED,
    output state_e                 dbg_state_o
);

    localparam int HB_W = (HB_STEPS > 1) ? $clog2(HB_STEPS) : 1;
    localparam logic [HB_W-1:0]   HB_LAST  = HB_W'(HB_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;
    localparam logic [N_REQ-1:0]  ACK_ONE  = N_REQ'(1);

    state_e              state_q;
    logic [N_REQ-1:0]    ack_q;
    logic                busy_q;
    logic [ID_W-1:0]     gnt_q;
    logic                done_q;
    logic                led_q;
    logic [PAT_W-1:0]    pat_q;
    logic [REP_W-1:0]    rep_q;
    logic [STEP_W-1:0]   step_q;
    logic [HB_W-1:0]     hb_q;

    logic                tick;
    logic                clr;
    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [PAT_W-1:0]    win_pat;
    logic [REP_W-1:0]    win_rep;
    logic                play_end;

    // Lowest set index wins: scanning from the top down lets the lowest
    // index overwrite any higher one.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    assign win_pat = pattern[PAT_W*int'(win_idx) +: PAT_W];
    assign win_rep = reps[REP_W*int'(win_idx) +: REP_W];

    assign play_end = (state_q == S_PLAY) && tick && (step_q == STEP_MAX)
                      && (rep_q == '0);

    // Prescaler restarts on every state change so each step and the
    // post-play heartbeat start from a full period. A replay stays in
    // S_PLAY and needs no clear: the count wraps on that tick anyway.
    assign clr = ((state_q == S_IDLE) && win_found) || play_end
                 || (state_q == S_DONE);

    tick_gen #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .in_rst (in_rst),
        .clr    (clr),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= S_IDLE;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            led_q   <= 1'b0;
            pat_q   <= '0;
            rep_q   <= '0;
            step_q  <= '0;
            hb_q    <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        // A tick on this edge is dropped: the grant wins.
                        ack_q   <= ACK_ONE << win_idx;
                        pat_q   <= win_pat;
                        rep_q   <= win_rep;
                        gnt_q   <= win_idx;
                        busy_q  <= 1'b1;
                        step_q  <= '0;
                        led_q   <= win_pat[PAT_W-1];
                        state_q <= S_PLAY;
                    end else if (tick) begin
                        if (hb_q == HB_LAST) begin
                            hb_q  <= '0;
                            led_q <= ~led_q;
                        end else begin
                            hb_q <= hb_q + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        if (step_q == STEP_MAX) begin
                            if (rep_q != '0) begin
                                rep_q  <= rep_q - 1'b1;
                                step_q <= '0;
                                led_q  <= pat_q[PAT_W-1];
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                gnt_q   <= '0;
                                led_q   <= 1'b0;
                                hb_q    <= '0;
                            end
                        end else begin
                            // LED already shows the next step's bit while
                            // step_q advances, keeping LED aligned to step.
                            step_q <= step_q + 1'b1;
                            led_q  <= pat_q[4'd14 - step_q];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign busy        = busy_q;
    assign gnt_id      = gnt_q;
    assign done        = done_q;
    assign LED         = led_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_scheduler.sv
// tb_led_scheduler
//   Directed bench for led_scheduler with STEP_CYCLES=4, HB_STEPS=2, N_REQ=3.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_scheduler;
    import led_sched_pkg::*;

    localparam int N_REQ = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic in_rst = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*16-1:0] pattern = '0;
    logic [N_REQ*4-1:0]  reps = '0;
    logic [N_REQ-1:0]    ack;
    logic                busy;
    logic [1:0]          gnt_id;
    logic                done;
    logic                LED;
    state_e              dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    led_scheduler #(
        .N_REQ(N_REQ),
        .STEP_CYCLES(4),
        .HB_STEPS(2)
    ) dut (
        .clk         (clk),
        .in_rst      (in_rst),
        .req         (req),
        .pattern     (pattern),
        .reps        (reps),
        .ack         (ack),
        .busy        (busy),
        .gnt_id      (gnt_id),
        .done        (done),
        .LED         (LED),
        .dbg_state_o (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_gnt"}, 32'(gnt_id), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_led"}, 32'(LED), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    // Heartbeat from a fresh prescaler: edges 1..7 LED=0, 8..15 LED=1,
    // edge 16 back to 0. No grant activity expected.
    task automatic hb_check(input string tag);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk({tag, "_led"}, 32'(LED), (k >= 8 && k < 16) ? 32'd1 : 32'd0);
            chk({tag, "_ack"}, 32'(ack), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            chk({tag, "_done"}, 32'(done), 32'd0);
        end
    endtask

    // Called on the falling edge where ack is expected. Checks every cycle
    // of the play(s) and the done cycle that follows.
    task automatic play_check(input string tag, input logic [15:0] pat, input int nrep,
                              input int id, input logic [2:0] drop_mask,
                              input int raise_at, input logic [2:0] raise_mask);
        logic [2:0] exp_ack;
        exp_ack = 3'(1) << id;
        for (int c = 0; c < (nrep + 1) * 64; c++) begin
            if (c > 0) @(negedge clk);
            chk({tag, "_led"}, 32'(LED), 32'(pat[15 - (c % 64) / 4]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_gnt"}, 32'(gnt_id), 32'(id));
            chk({tag, "_ack"}, 32'(ack), (c == 0) ? 32'(exp_ack) : 32'd0);
            chk({tag, "_done"}, 32'(done), 32'd0);
            if (c == 0) req = req & ~drop_mask;
            if (c == raise_at) req = req | raise_mask;
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_gnt"}, 32'(gnt_id), 32'd0);
        chk({tag, "_done_led"}, 32'(LED), 32'd0);
        chk({tag, "_done_ack"}, 32'(ack), 32'd0);
        chk({tag, "_done_state"}, 32'(dbg_state), 32'(S_DONE));
    endtask

    task automatic idle_gap(input string tag);
        @(negedge clk);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held for a few cycles
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        in_rst = 1'b1;

        // 1) heartbeat after reset
        hb_check("hb0");

        // 2) single request from requester 1, pattern A000, one play
        pattern[31:16] = 16'hA000;
        reps[7:4] = 4'd0;
        req = 3'b010;
        @(negedge clk);
        play_check("r1", 16'hA000, 0, 1, 3'b010, -1, 3'b000);
        idle_gap("r1_gap");

        // 3) simultaneous req[0] and req[2]: 0 wins, 2 follows after done
        pattern[15:0]  = 16'hC003;
        reps[3:0]      = 4'd0;
        pattern[47:32] = 16'h0F0F;
        reps[11:8]     = 4'd0;
        req = 3'b101;
        @(negedge clk);
        play_check("r0a", 16'hC003, 0, 0, 3'b001, -1, 3'b000);
        chk("r2_waiting_req", 32'(req), 32'b100);
        idle_gap("r0a_gap");

        // 4) req[2] plays; req[0] raised mid-play with a repeated pattern
        pattern[15:0] = 16'h8001;
        reps[3:0]     = 4'd2;
        @(negedge clk);
        play_check("r2", 16'h0F0F, 0, 2, 3'b100, 20, 3'b001);
        idle_gap("r2_gap");

        // 5) req[0]: 8001 played three times, single done at the end
        @(negedge clk);
        play_check("r0b", 16'h8001, 2, 0, 3'b001, -1, 3'b000);
        idle_gap("r0b_gap");

        // 6) reset mid-play at step 7
        pattern[31:16] = 16'hFFFF;
        reps[7:4] = 4'd0;
        req = 3'b010;
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'b010);
        req = '0;
        repeat (29) @(negedge clk);
        chk("rst_pre_led", 32'(LED), 32'd1);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2 in_rst = 1'b0;
        #1 chk_all_zero("rst_async");
        @(negedge clk);
        chk_all_zero("rst_hold");
        in_rst = 1'b1;
        hb_check("hb1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
